// File: rtl/alt_eyemon_dprio_serializer.sv
// ----------------------------------------------------------------------------
// alt_eyemon_dprio_serializer
//
// Back end of the eye-monitor AVMM-to-DPRIO bridge. The bridge hands over a
// single-cycle parallel request (wren/rden, address, data). This block runs
// it on the transceiver's serial DPRIO pins as two frames: an address frame,
// then a write or read frame. For reads it returns the data in parallel.
//
// Frame  : 2-bit opcode then payload, both MSB first.
//          Opcodes: address 2'b00, write 2'b01, read 2'b11.
// Bit    : 2 ticks of CLK_DIV cycles each. sclk is low in tick 0 and high in
//          tick 1. sdo changes only at the start of tick 0. sdi is sampled on
//          the edge where sclk rises, and only for payload bits.
//
// Ports
//   i_avmm_clk     clock for all logic
//   i_reset        synchronous, active-high reset
//   i_dprio_wren   write request (looked at only while idle; wins over rden)
//   i_dprio_rden   read request (looked at only while idle)
//   i_dprio_addr   request address
//   i_dprio_data   write data
//   o_dprio_busy   high from the cycle after acceptance through DONE
//   o_dprio_in     data from the last completed read
//   o_dprio_csn    serial frame select, active low
//   o_dprio_sclk   serial clock
//   o_dprio_sdo    serial data to the transceiver
//   i_dprio_sdi    serial data from the transceiver
// ----------------------------------------------------------------------------
module alt_eyemon_dprio_serializer #(
    parameter int DPRIO_ADDR_WIDTH = 16,
    parameter int DPRIO_DATA_WIDTH = 16,
    parameter int CLK_DIV          = 2
) (
    input  logic                        i_avmm_clk,
    input  logic                        i_reset,
    input  logic                        i_dprio_wren,
    input  logic                        i_dprio_rden,
    input  logic [DPRIO_ADDR_WIDTH-1:0] i_dprio_addr,
    input  logic [DPRIO_DATA_WIDTH-1:0] i_dprio_data,
    output logic                        o_dprio_busy,
    output logic [DPRIO_DATA_WIDTH-1:0] o_dprio_in,
    output logic                        o_dprio_csn,
    output logic                        o_dprio_sclk,
    output logic                        o_dprio_sdo,
    input  logic                        i_dprio_sdi
);

    localparam int F_ADDR = DPRIO_ADDR_WIDTH + 2;
    localparam int F_DATA = DPRIO_DATA_WIDTH + 2;
    localparam int F_MAX  = (F_ADDR > F_DATA) ? F_ADDR : F_DATA;
    localparam int BIT_W  = $clog2(F_MAX);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BIT_W-1:0] ADDR_LAST     = BIT_W'(F_ADDR - 1);
    localparam logic [BIT_W-1:0] DATA_LAST     = BIT_W'(F_DATA - 1);
    localparam logic [BIT_W-1:0] FIRST_PAYLOAD = BIT_W'(2);
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_GAP,
        ST_DATA,
        ST_DONE
    } state_t;

    state_t                      state_reg, state_next;
    logic [DIV_W-1:0]            div_reg, div_next;    // cycle within a tick
    logic                        half_reg, half_next;  // 0 = tick 0, 1 = tick 1
    logic [BIT_W-1:0]            bit_reg, bit_next;    // bit index within a frame
    logic                        op_write_reg, op_write_next;
    logic [DPRIO_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DPRIO_DATA_WIDTH-1:0] data_reg, data_next;
    logic [DPRIO_DATA_WIDTH-1:0] rx_reg, rx_next;
    logic [DPRIO_DATA_WIDTH-1:0] in_next;
    logic                        busy_next, csn_next, sclk_next, sdo_next;
    logic                        tick_end;

    // The frames are stored bit-reversed, so entry k is the k-th bit on the
    // wire and bit_next can index them directly. They are built from the
    // *_next values so the first bit is correct on the acceptance edge.
    logic [F_ADDR-1:0] addr_rev;
    logic [F_DATA-1:0] data_rev;

    genvar gi;
    generate
        for (gi = 0; gi < F_ADDR; gi++) begin : g_addr_frame
            if (gi < 2) begin : g_op
                assign addr_rev[gi] = 1'b0;
            end else begin : g_payload
                assign addr_rev[gi] = addr_next[F_ADDR-1-gi];
            end
        end
        for (gi = 0; gi < F_DATA; gi++) begin : g_data_frame
            if (gi == 0) begin : g_op_hi
                assign data_rev[gi] = ~op_write_next;
            end else if (gi == 1) begin : g_op_lo
                assign data_rev[gi] = 1'b1;
            end else begin : g_payload
                // The read frame has no meaningful payload, so it is sent as zeros.
                assign data_rev[gi] = op_write_next & data_next[F_DATA-1-gi];
            end
        end
    endgenerate

    assign tick_end = (div_reg == DIV_LAST);

    // Next-state and datapath
    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        half_next     = half_reg;
        bit_next      = bit_reg;
        op_write_next = op_write_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        rx_next       = rx_reg;
        in_next       = o_dprio_in;

        case (state_reg)
            ST_IDLE: begin
                if (i_dprio_wren || i_dprio_rden) begin
                    state_next    = ST_ADDR;
                    op_write_next = i_dprio_wren;
                    addr_next     = i_dprio_addr;
                    data_next     = i_dprio_data;
                    div_next      = '0;
                    half_next     = 1'b0;
                    bit_next      = '0;
                end
            end
            // GAP runs on the same tick counters, so it lasts exactly one bit time.
            ST_ADDR, ST_GAP, ST_DATA: begin
                div_next = tick_end ? '0 : div_reg + 1'b1;
                if (tick_end) begin
                    half_next = ~half_reg;
                    if (half_reg) begin
                        if (state_reg == ST_GAP) begin
                            state_next = ST_DATA;
                            bit_next   = '0;
                        end else if (state_reg == ST_ADDR && bit_reg == ADDR_LAST) begin
                            state_next = ST_GAP;
                            bit_next   = '0;
                        end else if (state_reg == ST_DATA && bit_reg == DATA_LAST) begin
                            state_next = ST_DONE;
                            bit_next   = '0;
                        end else begin
                            bit_next = bit_reg + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                if (!op_write_reg) begin
                    in_next = rx_reg;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Sample on the edge where sclk goes 0->1 (end of tick 0).
        if (state_reg == ST_DATA && !op_write_reg && tick_end && !half_reg
                && bit_reg >= FIRST_PAYLOAD) begin
            rx_next = {rx_reg[DPRIO_DATA_WIDTH-2:0], i_dprio_sdi};
        end
    end

    // Pin values follow the next state, so after each edge the registered
    // outputs match the state register.
    always_comb begin
        busy_next = (state_next != ST_IDLE);
        csn_next  = 1'b1;
        sclk_next = 1'b0;
        sdo_next  = 1'b0;
        if (state_next == ST_ADDR) begin
            csn_next  = 1'b0;
            sclk_next = half_next;
            sdo_next  = addr_rev[bit_next];
        end else if (state_next == ST_DATA) begin
            csn_next  = 1'b0;
            sclk_next = half_next;
            sdo_next  = data_rev[bit_next];
        end
    end

    always_ff @(posedge i_avmm_clk) begin
        if (i_reset) begin
            state_reg    <= ST_IDLE;
            div_reg      <= '0;
            half_reg     <= 1'b0;
            bit_reg      <= '0;
            op_write_reg <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            rx_reg       <= '0;
            o_dprio_in   <= '0;
            o_dprio_busy <= 1'b0;
            o_dprio_csn  <= 1'b1;
            o_dprio_sclk <= 1'b0;
            o_dprio_sdo  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            half_reg     <= half_next;
            bit_reg      <= bit_next;
            op_write_reg <= op_write_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            rx_reg       <= rx_next;
            o_dprio_in   <= in_next;
            o_dprio_busy <= busy_next;
            o_dprio_csn  <= csn_next;
            o_dprio_sclk <= sclk_next;
            o_dprio_sdo  <= sdo_next;
        end
    end

endmodule

// File: tb/tb_alt_eyemon_dprio_serializer.sv
// ----------------------------------------------------------------------------
// Bench for alt_eyemon_dprio_serializer.
// Instance 0 runs with CLK_DIV=2 and instance 1 with CLK_DIV=1. A pin-level
// monitor and serial slave runs for each instance. It captures frames,
// measures the busy, gap and sclk phase lengths, and drives sdi.
// Expectations come from the frame and timing rules:
//   - address frame {00, addr}, then {01, data} for a write or {11, -} for a read
//   - busy lasts 74*CLK_DIV+1 cycles and the gap lasts 2*CLK_DIV cycles
//   - a read returns the slave's response
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alt_eyemon_dprio_serializer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] addr_s, data_s;
    logic        wren [2];
    logic        rden [2];
    logic        sdi  [2];
    logic        busy [2];
    logic        csn  [2];
    logic        sclk [2];
    logic        sdo  [2];
    logic [15:0] din  [2];

    alt_eyemon_dprio_serializer #(
        .DPRIO_ADDR_WIDTH(16), .DPRIO_DATA_WIDTH(16), .CLK_DIV(2)
    ) dut0 (
        .i_avmm_clk(clk), .i_reset(rst),
        .i_dprio_wren(wren[0]), .i_dprio_rden(rden[0]),
        .i_dprio_addr(addr_s), .i_dprio_data(data_s),
        .o_dprio_busy(busy[0]), .o_dprio_in(din[0]),
        .o_dprio_csn(csn[0]), .o_dprio_sclk(sclk[0]), .o_dprio_sdo(sdo[0]),
        .i_dprio_sdi(sdi[0])
    );

    alt_eyemon_dprio_serializer #(
        .DPRIO_ADDR_WIDTH(16), .DPRIO_DATA_WIDTH(16), .CLK_DIV(1)
    ) dut1 (
        .i_avmm_clk(clk), .i_reset(rst),
        .i_dprio_wren(wren[1]), .i_dprio_rden(rden[1]),
        .i_dprio_addr(addr_s), .i_dprio_data(data_s),
        .o_dprio_busy(busy[1]), .o_dprio_in(din[1]),
        .o_dprio_csn(csn[1]), .o_dprio_sclk(sclk[1]), .o_dprio_sdo(sdo[1]),
        .i_dprio_sdi(sdi[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int cd(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // Monitor results, read and cleared by the main flow
    int          nframes [2];
    int          nfalls  [2];
    int          busy_len[2];
    int          gap_last[2];
    int          viol    [2];
    logic [31:0] frm_bits[2][4];
    int          frm_len [2][4];
    logic [15:0] in_fall [2];
    // Monitor internal state
    int          bcnt[2], gap_run[2], busy_run[2], hi_run[2], lo_run[2];
    logic [31:0] shreg[2];
    logic        busy_p[2], csn_p[2], sclk_p[2], sdo_p[2];
    logic [17:0] resp[2];       // slave reply: a full frame, MSB first
    logic [15:0] exp_in[2];     // model of o_dprio_in

    // Monitor and slave. Sampling happens on negedge, away from the DUT edge.
    initial begin
        logic [17:0] tmp;
        for (int i = 0; i < 2; i++) begin
            sdi[i] = 1'b0; nframes[i] = 0; nfalls[i] = 0; viol[i] = 0;
            busy_len[i] = 0; gap_last[i] = 0; resp[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    bcnt[i] = 0; gap_run[i] = 0; busy_run[i] = 0;
                    hi_run[i] = 0; lo_run[i] = 0; shreg[i] = '0;
                end else begin
                    // pin rules
                    if (csn[i]) begin
                        if (sclk[i] !== 1'b0 || sdo[i] !== 1'b0) viol[i]++;
                    end else if (!csn_p[i]) begin
                        if (sdo[i] != sdo_p[i] && !(sclk_p[i] && !sclk[i])) viol[i]++;
                    end
                    if (sclk[i]) begin
                        hi_run[i]++;
                    end else begin
                        if (sclk_p[i] && hi_run[i] != cd(i)) viol[i]++;
                        hi_run[i] = 0;
                    end
                    if (csn[i]) begin
                        lo_run[i] = 0;
                    end else if (!sclk[i]) begin
                        lo_run[i]++;
                    end else if (!sclk_p[i]) begin
                        if (lo_run[i] != cd(i)) viol[i]++;
                        lo_run[i] = 0;
                    end
                    // frames and the gap between them
                    if (!csn[i] && csn_p[i]) begin
                        gap_last[i] = gap_run[i]; gap_run[i] = 0;
                        bcnt[i] = 0; shreg[i] = '0;
                    end else if (busy[i] && csn[i]) begin
                        gap_run[i]++;
                    end
                    if (!csn[i] && sclk[i] && !sclk_p[i]) begin
                        shreg[i] = {shreg[i][30:0], sdo[i]};
                        bcnt[i]++;
                    end
                    if (csn[i] && !csn_p[i]) begin
                        if (nframes[i] < 4) begin
                            frm_bits[i][nframes[i]] = shreg[i];
                            frm_len[i][nframes[i]]  = bcnt[i];
                        end
                        nframes[i]++;
                        bcnt[i] = 0;
                    end
                    // busy
                    if (busy[i]) begin
                        busy_run[i]++;
                    end else if (busy_p[i]) begin
                        busy_len[i] = busy_run[i];
                        in_fall[i]  = din[i];
                        nfalls[i]++;
                        busy_run[i] = 0;
                    end
                end
                busy_p[i] = busy[i]; csn_p[i] = csn[i];
                sclk_p[i] = sclk[i]; sdo_p[i] = sdo[i];
                // Slave: after k rising sclk edges, present bit k of the reply.
                tmp = resp[i] << bcnt[i];
                sdi[i] = (!csn[i] && bcnt[i] < 18) ? tmp[17] : 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon(input int i);
        nframes[i] = 0; nfalls[i] = 0; viol[i] = 0;
    endtask

    task automatic wait_busy(input int i, input logic lvl, input string tag);
        int n;
        n = 0;
        while (busy[i] !== lvl && n < 400) begin
            tick();
            n++;
        end
        if (busy[i] !== lvl) check(tag, 32'(busy[i]), 32'(lvl));
    endtask

    task automatic verify(input int i, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] r);
        if (!wr) exp_in[i] = r;
        check("frame_count", nframes[i], 2);
        check("addr_frame_len", frm_len[i][0], 18);
        check("addr_frame", frm_bits[i][0], {16'h0000, a});
        check("data_frame_len", frm_len[i][1], 18);
        if (wr) check("write_frame", frm_bits[i][1], {14'h0, 2'b01, d});
        else    check("read_opcode", 32'(frm_bits[i][1][17:16]), 32'h3);
        check("busy_len", busy_len[i], 74 * cd(i) + 1);
        check("gap_len", gap_last[i], 2 * cd(i));
        check("pin_timing_violations", viol[i], 0);
        check("busy_falls", nfalls[i], 1);
        check("rdata_at_busy_fall", 32'(in_fall[i]), 32'(exp_in[i]));
        $display("txn inst=%0d clk_div=%0d %s addr=%h data=%h o_dprio_in=%h busy_len=%0d",
                 i, cd(i), wr ? "WR" : "RD", a, wr ? d : r, in_fall[i], busy_len[i]);
        clear_mon(i);
    endtask

    task automatic pulse_txn(input int i, input logic wr, input logic rd, input logic [15:0] a,
                             input logic [15:0] d, input logic [15:0] r);
        resp[i] = {2'b00, r};
        addr_s = a; data_s = d; wren[i] = wr; rden[i] = rd;
        tick();
        wren[i] = 1'b0; rden[i] = 1'b0;
        check("busy_rise_next_cycle", 32'(busy[i]), 1);
        wait_busy(i, 1'b0, "busy_fall_timeout");
        tick();
        verify(i, wr, a, d, r);
    endtask

    task automatic hs_read(input int i, input logic [15:0] a, input logic [15:0] r);
        resp[i] = {2'b00, r};
        addr_s = a; rden[i] = 1'b1;
        wait_busy(i, 1'b1, "hs_accept_timeout");
        rden[i] = 1'b0;
        wait_busy(i, 1'b0, "hs_done_timeout");
        tick();
        verify(i, 1'b0, a, 16'h0000, r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, d, r, d2;
        logic        wr, rd;
        int          low;
        rst = 1'b1; addr_s = '0; data_s = '0;
        for (int i = 0; i < 2; i++) begin
            wren[i] = 1'b0; rden[i] = 1'b0; exp_in[i] = '0;
        end
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_busy", 32'(busy[i]), 0);
            check("rst_csn", 32'(csn[i]), 1);
            check("rst_sclk", 32'(sclk[i]), 0);
            check("rst_sdo", 32'(sdo[i]), 0);
            check("rst_in", 32'(din[i]), 0);
        end
        rst = 1'b0;
        repeat (2) tick();
        clear_mon(0); clear_mon(1);

        // Directed cases on CLK_DIV=2
        pulse_txn(0, 1'b1, 1'b0, 16'h1234, 16'hABCD, 16'h0000);
        pulse_txn(0, 1'b0, 1'b1, 16'h0F0F, 16'h0000, 16'h5A5A);

        // A request while busy is ignored; the latched address is unaffected.
        resp[0] = '0; addr_s = 16'h4321; data_s = 16'h8765; wren[0] = 1'b1;
        tick();
        wren[0] = 1'b0;
        check("busy_rise_next_cycle", 32'(busy[0]), 1);
        repeat (20) tick();
        addr_s = 16'h1111; data_s = 16'h2222; wren[0] = 1'b1;
        tick();
        wren[0] = 1'b0;
        wait_busy(0, 1'b0, "busy_fall_timeout");
        tick();
        verify(0, 1'b1, 16'h4321, 16'h8765, 16'h0000);
        repeat (200) tick();
        check("no_extra_frame", nframes[0], 0);
        check("no_extra_busy", nfalls[0], 0);

        // A request held across the end of busy is taken after one idle cycle.
        d = 16'($urandom); d2 = 16'($urandom);
        addr_s = 16'h3333; data_s = d; wren[0] = 1'b1;
        tick();
        wren[0] = 1'b0;
        repeat (30) tick();
        addr_s = 16'h2222; data_s = d2; wren[0] = 1'b1;
        wait_busy(0, 1'b0, "busy_fall_timeout");
        low = 0;
        while (busy[0] === 1'b0 && low < 10) begin
            tick();
            low++;
        end
        wren[0] = 1'b0;
        check("busy_low_cycles", low, 1);
        verify(0, 1'b1, 16'h3333, d, 16'h0000);
        wait_busy(0, 1'b0, "busy_fall_timeout");
        tick();
        verify(0, 1'b1, 16'h2222, d2, 16'h0000);

        // wren and rden together: the write wins.
        pulse_txn(0, 1'b1, 1'b1, 16'h0002, 16'hC3C3, 16'hFFFF);

        // Random transactions, CLK_DIV=2
        for (int k = 0; k < 6; k++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            a = 16'($urandom); d = 16'($urandom); r = 16'($urandom);
            pulse_txn(0, wr, rd, a, d, r);
        end

        // Reset in the middle of a read's data frame
        resp[0] = {2'b00, 16'h9C9C}; addr_s = 16'hBEEF; rden[0] = 1'b1;
        tick();
        rden[0] = 1'b0;
        repeat (100) tick();
        check("in_data_frame_before_rst", 32'(csn[0]), 0);
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy[0]), 0);
        check("midrst_csn", 32'(csn[0]), 1);
        check("midrst_sclk", 32'(sclk[0]), 0);
        check("midrst_sdo", 32'(sdo[0]), 0);
        check("midrst_in", 32'(din[0]), 0);
        rst = 1'b0;
        exp_in[0] = '0; exp_in[1] = '0;
        repeat (3) tick();
        clear_mon(0); clear_mon(1);
        check("in_after_rst", 32'(din[0]), 0);
        pulse_txn(0, 1'b1, 1'b0, 16'h5555, 16'h0F0F, 16'h0000);

        // CLK_DIV=1: back-to-back reads with a bridge-style handshake
        hs_read(1, 16'h0001, 16'($urandom));
        hs_read(1, 16'h0002, 16'($urandom));
        for (int k = 0; k < 6; k++) begin
            wr = 1'($urandom_range(0, 1));
            rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            a = 16'($urandom); d = 16'($urandom); r = 16'($urandom);
            pulse_txn(1, wr, rd, a, d, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
